// File: rtl/sprite_motion.sv
// sprite_motion: per-frame position engine for SPR_CNT sprite channels.
// A frame pulse starts a sequencer that steps one channel per clock; a register port loads channel state.
module sprite_motion #(
  parameter int CORDW   = 16,
  parameter int SPR_CNT = 4,
  parameter int H_RES   = 480,
  parameter int V_RES   = 272,
  parameter int SPR_W   = 64,
  parameter int SPR_H   = 64,
  parameter int VELW    = 4,
  localparam int IDXW   = (SPR_CNT > 1) ? $clog2(SPR_CNT) : 1
) (
  input  logic                       clk_pix,
  input  logic                       rst_pix,
  input  logic                       frame,
  input  logic                       wr_en,
  input  logic [IDXW-1:0]            wr_idx,
  input  logic [1:0]                 wr_sel,
  input  logic [CORDW-1:0]           wr_data,
  output logic [SPR_CNT*CORDW-1:0]   sprx,
  output logic [SPR_CNT*CORDW-1:0]   spry,
  output logic [SPR_CNT-1:0]         hit,
  output logic                       busy,
  output logic                       overrun
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_UPDATE = 1'b1;

  localparam logic [1:0] MODE_STOP   = 2'd0;
  localparam logic [1:0] MODE_WRAP   = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_RASTER = 2'd3;

  localparam logic [1:0] SEL_X    = 2'd0;
  localparam logic [1:0] SEL_Y    = 2'd1;
  localparam logic [1:0] SEL_VEL  = 2'd2;
  localparam logic [1:0] SEL_MODE = 2'd3;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SPR_CNT - 1);

  localparam logic signed [CORDW-1:0] ZERO_C  = '0;
  localparam logic signed [CORDW-1:0] HRES_C  = CORDW'(H_RES);
  localparam logic signed [CORDW-1:0] VRES_C  = CORDW'(V_RES);
  localparam logic signed [CORDW-1:0] HLAST_C = CORDW'(H_RES - 1);
  localparam logic signed [CORDW-1:0] VLAST_C = CORDW'(V_RES - 1);
  localparam logic signed [CORDW-1:0] HNEG_C  = CORDW'(-SPR_W);
  localparam logic signed [CORDW-1:0] VNEG_C  = CORDW'(-SPR_H);
  localparam logic signed [CORDW-1:0] HMAX_C  = CORDW'(H_RES - SPR_W);
  localparam logic signed [CORDW-1:0] VMAX_C  = CORDW'(V_RES - SPR_H);
  localparam logic signed [CORDW-1:0] SPRW_C  = CORDW'(SPR_W);
  localparam logic signed [CORDW-1:0] SPRH_C  = CORDW'(SPR_H);

  localparam logic signed [VELW-1:0] VEL_MIN = {1'b1, {(VELW-1){1'b0}}};
  localparam logic signed [VELW-1:0] VEL_MAX = {1'b0, {(VELW-1){1'b1}}};

  logic signed [CORDW-1:0] pos_x [SPR_CNT];
  logic signed [CORDW-1:0] pos_y [SPR_CNT];
  logic signed [VELW-1:0]  vel_x [SPR_CNT];
  logic signed [VELW-1:0]  vel_y [SPR_CNT];
  logic [1:0]              mode  [SPR_CNT];
  logic [SPR_CNT-1:0]      hit_r;
  logic [0:0]              state;
  logic [IDXW-1:0]         idx;

  logic signed [CORDW-1:0] cur_x, cur_y, nx, ny, upd_x, upd_y;
  logic signed [VELW-1:0]  cur_vx, cur_vy, upd_vx, upd_vy;
  logic [1:0]              cur_mode;
  logic                    upd_hit;

  function automatic logic signed [CORDW-1:0] sext_vel(input logic signed [VELW-1:0] v);
    sext_vel = {{(CORDW-VELW){v[VELW-1]}}, v};
  endfunction

  // The most negative velocity has no positive twin, so it reflects to the largest positive one.
  function automatic logic signed [VELW-1:0] neg_sat(input logic signed [VELW-1:0] v);
    if (v == VEL_MIN) neg_sat = VEL_MAX;
    else              neg_sat = -v;
  endfunction

  function automatic logic signed [CORDW-1:0] wrap_pos(
    input logic signed [CORDW-1:0] p,
    input logic signed [CORDW-1:0] lim,
    input logic signed [CORDW-1:0] last,
    input logic signed [CORDW-1:0] neg
  );
    if (p >= lim)      wrap_pos = neg;
    else if (p <= neg) wrap_pos = last;
    else               wrap_pos = p;
  endfunction

  // Stage: next-state of the channel selected by the sequencer
  always_comb begin
    cur_x    = pos_x[idx];
    cur_y    = pos_y[idx];
    cur_vx   = vel_x[idx];
    cur_vy   = vel_y[idx];
    cur_mode = mode[idx];
    nx       = cur_x + sext_vel(cur_vx);
    ny       = cur_y + sext_vel(cur_vy);
    upd_x    = cur_x;
    upd_y    = cur_y;
    upd_vx   = cur_vx;
    upd_vy   = cur_vy;
    upd_hit  = 1'b0;
    case (cur_mode)
      MODE_WRAP: begin
        upd_x = wrap_pos(nx, HRES_C, HLAST_C, HNEG_C);
        upd_y = wrap_pos(ny, VRES_C, VLAST_C, VNEG_C);
      end
      MODE_BOUNCE: begin
        if (nx < ZERO_C) begin
          upd_x = ZERO_C; upd_vx = neg_sat(cur_vx); upd_hit = 1'b1;
        end else if (nx > HMAX_C) begin
          upd_x = HMAX_C; upd_vx = neg_sat(cur_vx); upd_hit = 1'b1;
        end else begin
          upd_x = nx;
        end
        if (ny < ZERO_C) begin
          upd_y = ZERO_C; upd_vy = neg_sat(cur_vy); upd_hit = 1'b1;
        end else if (ny > VMAX_C) begin
          upd_y = VMAX_C; upd_vy = neg_sat(cur_vy); upd_hit = 1'b1;
        end else begin
          upd_y = ny;
        end
      end
      MODE_RASTER: begin
        if (cur_x < HRES_C) begin
          upd_x = cur_x + SPRW_C;
        end else begin
          upd_x = ZERO_C;
          upd_y = (cur_y < VRES_C) ? cur_y + SPRH_C : ZERO_C;
        end
      end
      default: ;
    endcase
  end

  // Stage: channel registers; register-port writes land after the update so they win per field
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state   <= ST_IDLE;
      idx     <= '0;
      overrun <= 1'b0;
      hit_r   <= '0;
      for (int i = 0; i < SPR_CNT; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
        vel_x[i] <= '0;
        vel_y[i] <= '0;
        mode[i]  <= MODE_STOP;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame) begin
            state <= ST_UPDATE;
            idx   <= '0;
          end
        end
        ST_UPDATE: begin
          if (frame) overrun <= 1'b1;
          pos_x[idx] <= upd_x;
          pos_y[idx] <= upd_y;
          vel_x[idx] <= upd_vx;
          vel_y[idx] <= upd_vy;
          hit_r[idx] <= upd_hit;
          if (idx == LAST_IDX) begin
            state <= ST_IDLE;
            idx   <= '0;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (wr_en) begin
        case (wr_sel)
          SEL_X:   pos_x[wr_idx] <= wr_data;
          SEL_Y:   pos_y[wr_idx] <= wr_data;
          SEL_VEL: begin
            vel_x[wr_idx] <= wr_data[VELW-1:0];
            vel_y[wr_idx] <= wr_data[2*VELW-1:VELW];
          end
          SEL_MODE: mode[wr_idx] <= wr_data[1:0];
          default: ;
        endcase
      end
    end
  end

  assign busy = (state == ST_UPDATE);
  assign hit  = hit_r;

  for (genvar g = 0; g < SPR_CNT; g++) begin : g_pack
    assign sprx[g*CORDW +: CORDW] = pos_x[g];
    assign spry[g*CORDW +: CORDW] = pos_y[g];
  end

endmodule
